// File: rtl/hub75_sink_if.sv
// hub75_sink_if: valid/ready pixel stream carrying one replayed HUB75 row
interface hub75_sink_if #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 5
) ();
    localparam int CW = $clog2(COLS);
    logic                pix_valid;
    logic                pix_ready;
    logic [ROW_BITS-1:0] pix_row;
    logic [CW-1:0]       pix_col;
    logic [2:0]          pix_rgb0;
    logic [2:0]          pix_rgb1;
    logic                pix_last;
    modport master (output pix_valid, pix_row, pix_col, pix_rgb0, pix_rgb1, pix_last, input pix_ready);
    modport slave  (input pix_valid, pix_row, pix_col, pix_rgb0, pix_rgb1, pix_last, output pix_ready);
endinterface

// File: rtl/hub75_sink.sv
// hub75_sink: HUB75 receiver that snapshots each latched row and replays it as a pixel stream
// Define HUB75_SINK_SYNC_EN to put a two-flop synchronizer on every bus input.
module hub75_sink #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 5
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [ROW_BITS-1:0] A,
    input  logic [2:0]          RGB0,
    input  logic [2:0]          RGB1,
    input  logic                CLK_SCREEN,
    input  logic                LATCH,
    input  logic                BLANK,
    input  logic                err_clr,
    hub75_sink_if.master        pix,
    output logic                blank_q,
    output logic                overrun,
    output logic                len_err
);
    localparam int CW = $clog2(COLS);
    localparam int IW = ROW_BITS + 9;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [IW-1:0] in_q;
`ifdef HUB75_SINK_SYNC_EN
    logic [IW-1:0] in_s;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            in_s <= '0;
            in_q <= '0;
        end else begin
            in_s <= {A, RGB1, RGB0, CLK_SCREEN, LATCH, BLANK};
            in_q <= in_s;
        end
`else
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) in_q <= '0;
        else in_q <= {A, RGB1, RGB0, CLK_SCREEN, LATCH, BLANK};
`endif

    assign blank_q = in_q[0];

    // Edge events are registered together with the data they qualify
    logic                cs_p, lat_p, shift_ev, latch_ev;
    logic [5:0]          rgb_d;
    logic [ROW_BITS-1:0] a_d;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            cs_p     <= 1'b0;
            lat_p    <= 1'b0;
            shift_ev <= 1'b0;
            latch_ev <= 1'b0;
            rgb_d    <= '0;
            a_d      <= '0;
        end else begin
            cs_p     <= in_q[2];
            lat_p    <= in_q[1];
            shift_ev <= in_q[2] & ~cs_p;
            latch_ev <= in_q[1] & ~lat_p;
            rgb_d    <= in_q[8:3];
            a_d      <= in_q[IW-1 -: ROW_BITS];
        end

    logic [5:0]          sbuf [COLS];
    logic [5:0]          sbuf_nxt [COLS];
    logic [5:0]          hold [COLS];
    logic [CW:0]         cnt, cnt_nxt;
    logic [0:0]          state;
    logic [CW-1:0]       col;
    logic [ROW_BITS-1:0] row;
    logic                accept, fire;

    // A shift coinciding with a latch lands in the snapshot and the length count
    always_comb begin
        for (int i = 0; i < COLS - 1; i++) sbuf_nxt[i] = shift_ev ? sbuf[i+1] : sbuf[i];
        sbuf_nxt[COLS-1] = shift_ev ? rgb_d : sbuf[COLS-1];
    end

    assign cnt_nxt = cnt + {{CW{1'b0}}, (shift_ev && cnt != '1)};
    assign accept  = latch_ev && state == IDLE;
    assign fire    = pix.pix_valid && pix.pix_ready;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            sbuf    <= '{default: '0};
            hold    <= '{default: '0};
            cnt     <= '0;
            state   <= IDLE;
            col     <= '0;
            row     <= '0;
            overrun <= 1'b0;
            len_err <= 1'b0;
        end else begin
            sbuf    <= sbuf_nxt;
            cnt     <= latch_ev ? '0 : cnt_nxt;
            overrun <= (latch_ev && state == STREAM) | (overrun & ~err_clr);
            len_err <= (accept && cnt_nxt != (CW+1)'(COLS)) | (len_err & ~err_clr);
            if (accept) begin
                hold  <= sbuf_nxt;
                row   <= a_d;
                col   <= '0;
                state <= STREAM;
            end else if (fire) begin
                col   <= col + CW'(1);
                state <= pix.pix_last ? IDLE : STREAM;
            end
        end

    assign pix.pix_valid = state == STREAM;
    assign pix.pix_row   = row;
    assign pix.pix_col   = col;
    assign pix.pix_rgb0  = hold[col][2:0];
    assign pix.pix_rgb1  = hold[col][5:3];
    assign pix.pix_last  = &col;
endmodule

// File: tb/tb_hub75_sink.sv
// tb_hub75_sink: scoreboard bench for hub75_sink (default build, no synchronizer)
module tb_hub75_sink;
    localparam int COLS = 64;
    localparam int ROW_BITS = 5;
    typedef logic [17:0] beat_t;

    logic       clk = 1'b0, resetn = 1'b0;
    logic [4:0] A = '0;
    logic [2:0] RGB0 = '0, RGB1 = '0;
    logic       CLK_SCREEN = 1'b0, LATCH = 1'b0, BLANK = 1'b0, err_clr = 1'b0;
    logic       blank_q, overrun, len_err;
    int         checks = 0, failures = 0;
    beat_t      sb[$];
    logic [5:0] mq[$];
    beat_t      got_b, exp_b;

    hub75_sink_if #(.COLS(COLS), .ROW_BITS(ROW_BITS)) pix();

    hub75_sink #(.COLS(COLS), .ROW_BITS(ROW_BITS)) dut (
        .clk(clk), .resetn(resetn), .A(A), .RGB0(RGB0), .RGB1(RGB1),
        .CLK_SCREEN(CLK_SCREEN), .LATCH(LATCH), .BLANK(BLANK), .err_clr(err_clr),
        .pix(pix), .blank_q(blank_q), .overrun(overrun), .len_err(len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk)
        if (resetn && pix.pix_valid && pix.pix_ready) begin
            got_b = {pix.pix_row, pix.pix_col, pix.pix_rgb0, pix.pix_rgb1, pix.pix_last};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL beat: unexpected beat got=%h (row,col,rgb0,rgb1,last)", got_b);
            end else begin
                exp_b = sb.pop_front();
                if (got_b !== exp_b) begin
                    failures++;
                    $display("FAIL beat: got=%h exp=%h (row,col,rgb0,rgb1,last)", got_b, exp_b);
                end
            end
        end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_px(input logic [5:0] p);
        mq.push_back(p);
        if (mq.size() > COLS) void'(mq.pop_front());
    endtask

    task automatic model_reset;
        mq.delete();
        for (int k = 0; k < COLS; k++) mq.push_back(6'd0);
    endtask

    task automatic shift_px(input logic [5:0] p);
        RGB0 = p[2:0];
        RGB1 = p[5:3];
        CLK_SCREEN = 1'b1;
        tick;
        CLK_SCREEN = 1'b0;
        tick;
        model_px(p);
    endtask

    task automatic latch(input logic [4:0] r);
        A = r;
        LATCH = 1'b1;
        tick;
        LATCH = 1'b0;
        tick;
    endtask

    task automatic push_row(input logic [4:0] r);
        for (int k = 0; k < COLS; k++)
            sb.push_back({r, 6'(k), mq[k][2:0], mq[k][5:3], k == COLS - 1});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 600 && sb.size() != 0; i++) tick;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s: drain timeout, %0d beats outstanding, exp 0", name, sb.size());
            sb.delete();
        end
        repeat (4) tick;
    endtask

    task automatic wait_col(input int c, input string name);
        bit found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (pix.pix_valid && pix.pix_col == 6'(c)) found = 1;
            else tick;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s: col %0d never presented, got col=%0d", name, c, pix.pix_col);
        end
    endtask

    task automatic pulse_clr;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        tick;
    endtask

    initial begin
        pix.pix_ready = 1'b1;
        model_reset();
        repeat (3) tick;
        chk("reset_outs", {pix.pix_valid, pix.pix_row, pix.pix_col, pix.pix_rgb0, pix.pix_rgb1,
                           pix.pix_last, blank_q, overrun, len_err}, 0);
        resetn = 1'b1;
        tick;
        BLANK = 1'b1;
        repeat (2) tick;
        chk("blank_q_set", blank_q, 1);
        BLANK = 1'b0;
        repeat (2) tick;
        chk("blank_q_clr", blank_q, 0);

        // Full row, pixel k = k
        for (int k = 0; k < COLS; k++) shift_px(6'(k));
        push_row(5'd5);
        latch(5'd5);
        chk("latency_pre", pix.pix_valid, 0);
        tick;
        chk("latency_post", pix.pix_valid, 1);
        drain("row_full");
        chk("len_err_full", len_err, 0);
        chk("idle_after_row", pix.pix_valid, 0);

        // Short row keeps 4 old pixels, then long row keeps last 64
        for (int k = 0; k < 60; k++) shift_px(6'((k * 3 + 1) & 63));
        push_row(5'd1);
        latch(5'd1);
        drain("row_short");
        chk("len_err_short", len_err, 1);
        pulse_clr();
        chk("len_err_cleared", len_err, 0);
        for (int k = 0; k < 70; k++) shift_px(6'((k * 7 + 2) & 63));
        push_row(5'd2);
        latch(5'd2);
        drain("row_long");
        chk("len_err_long", len_err, 1);
        pulse_clr();
        chk("len_err_cleared2", len_err, 0);

        // Second latch mid-stream is dropped
        for (int k = 0; k < COLS; k++) shift_px(6'(63 - k));
        push_row(5'd7);
        latch(5'd7);
        fork
            for (int i = 0; i < 160; i++) begin
                tick;
                pix.pix_ready = ~pix.pix_ready;
            end
            begin
                repeat (10) tick;
                latch(5'd9);
            end
        join
        pix.pix_ready = 1'b1;
        drain("row_overrun");
        chk("overrun_set", overrun, 1);
        chk("no_second_stream", pix.pix_valid, 0);
        pulse_clr();
        chk("overrun_cleared", overrun, 0);

        // 64th shift and latch rise together
        for (int k = 0; k < COLS - 1; k++) shift_px(6'((k * 5) & 63));
        model_px(6'h2a);
        push_row(5'd3);
        RGB0 = 3'h2;
        RGB1 = 3'h5;
        A = 5'd3;
        CLK_SCREEN = 1'b1;
        LATCH = 1'b1;
        tick;
        CLK_SCREEN = 1'b0;
        LATCH = 1'b0;
        tick;
        drain("row_simul");
        chk("len_err_simul", len_err, 0);

        // Stall at col 20
        for (int k = 0; k < COLS; k++) shift_px(6'(k ^ 6'h15));
        push_row(5'd11);
        latch(5'd11);
        wait_col(20, "stall_wait");
        pix.pix_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("stall_frozen", {pix.pix_valid, pix.pix_col, pix.pix_rgb1, pix.pix_rgb0},
                {1'b1, 6'd20, mq[20]});
        end
        pix.pix_ready = 1'b1;
        drain("row_stall");

        // Reset mid-stream at col 30
        for (int k = 0; k < COLS; k++) shift_px(6'(k ^ 6'h2c));
        push_row(5'd13);
        latch(5'd13);
        wait_col(30, "reset_wait");
        resetn = 1'b0;
        sb.delete();
        #1;
        chk("reset_async", {pix.pix_valid, pix.pix_row, pix.pix_col, pix.pix_rgb0, pix.pix_rgb1,
                            pix.pix_last, blank_q, overrun, len_err}, 0);
        tick;
        resetn = 1'b1;
        model_reset();
        repeat (3) tick;
        chk("no_stream_after_reset", pix.pix_valid, 0);
        for (int k = 0; k < COLS; k++) shift_px(6'(k ^ 6'h3f));
        push_row(5'd2);
        latch(5'd2);
        drain("row_after_reset");
        chk("len_err_after_reset", len_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
